// File: rtl/complement_pkg.sv
// Shared definitions for the serial complement unit.
//   state_t   : FSM encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   MODE_ONES : mode value selecting ones' complement
//   MODE_TWOS : mode value selecting twos' complement
package complement_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/complement_chunk.sv
// Combinational CHUNK-bit complement slice: y = ~a + cin, with carry-out.
// Ports:
//   a    in   CHUNK  operand slice
//   cin  in   1      carry in from the previous (lower) slice
//   y    out  CHUNK  complemented slice plus carry
//   cout out  1      carry out to the next (upper) slice
module complement_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic             cin,
  output logic [CHUNK-1:0] y,
  output logic             cout
);

  assign {cout, y} = {1'b0, ~a} + (CHUNK+1)'(cin);

endmodule

// File: rtl/complement_serial.sv
// Multi-cycle ones'/twos' complement unit with valid/ready handshakes.
// Works CHUNK bits per cycle, LSB chunk first, rippling the carry through a flop.
// Optional feature macro: COMPLEMENT_OVF_EN adds the ovf port (twos' of most-negative).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (I, mode)
//   I                     WIDTH-bit operand
//   mode                  0 = ones' complement, 1 = twos' complement
//   out_valid / out_ready result handshake (O)
//   O                     WIDTH-bit result, held until the next operation overwrites it
//   ovf                   twos' overflow flag (COMPLEMENT_OVF_EN only)
module complement_serial
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O
`ifdef COMPLEMENT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Parameter sanity checks at elaboration time
  if (WIDTH < 2) begin : g_bad_width
    $error("complement_serial: WIDTH must be >= 2");
  end
  if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("complement_serial: WIDTH must be a multiple of CHUNK");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_o;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_y;
  logic             w_cout;

  // Slice of the latched operand selected by the chunk counter
  assign w_a = r_op[int'(r_idx)*CHUNK +: CHUNK];

  complement_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (w_a),
    .cin  (r_carry),
    .y    (w_y),
    .cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; carry starts at 1 for twos'
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_o         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_op    <= I;
        r_carry <= (mode == MODE_TWOS);
        r_idx   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_o[int'(r_idx)*CHUNK +: CHUNK] <= w_y;
        r_carry <= w_cout;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign O         = r_o;

`ifdef COMPLEMENT_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic r_mode;
  logic r_ovf;

  // Most-negative value has no twos' negation; flag it for the DONE phase only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_ONES;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode <= mode;
      end
      r_ovf <= (w_state_nxt == ST_DONE) && (r_mode == MODE_TWOS) && (r_op == MOST_NEG);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
